// File: rtl/lane_select_encoder_pkg.sv
// ---------------------------------------------------------------------------
// lane_select_encoder_pkg
//
// Shared definitions for the lane select encoder and its lane counters.
//   NUM_LANES : number of approach lanes served by the intersection
//   LANE_*    : binary lane index values handed to the one-hot lane decoder
//   state_e   : phase of the light controller (all-red idle, green, yellow)
// ---------------------------------------------------------------------------
package lane_select_encoder_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] LANE_N = 2'd0;
    localparam logic [1:0] LANE_E = 2'd1;
    localparam logic [1:0] LANE_S = 2'd2;
    localparam logic [1:0] LANE_W = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_e;

endpackage

// File: rtl/lane_select_encoder_counter.sv
// ---------------------------------------------------------------------------
// lane_counter
//
// Saturating up/down counter holding the number of cars queued on one lane.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   inc_i   : one car arrived on this lane this cycle
//   dec_i   : one car left this lane this cycle
//   count_o : current queue length, saturates at 2^CNT_W-1 and floors at 0
// ---------------------------------------------------------------------------
module lane_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A simultaneous arrival and departure cancel out, so the count only
    // moves when exactly one of them is present. Arrivals at the ceiling and
    // departures from an empty lane are dropped.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/lane_select_encoder.sv
// ---------------------------------------------------------------------------
// lane_select_encoder
//
// Tracks queued cars on the N/E/S/W lanes, picks the busiest lane, holds it
// green for a bounded interval and then runs a yellow phase, followed by at
// least one all-red idle cycle before the next selection.
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   car_arrive_i  : per-lane arrival pulse, bit0=N 1=E 2=S 3=W
//   car_depart_i  : one car left through the currently green lane
//   largest_o     : selected lane index (N=0 E=1 S=2 W=3), feeds the decoder
//   green_valid_o : selected lane is green
//   yellow_o      : selected lane is in its yellow phase
//   lane_cnt_o    : packed per-lane counts, N in the least significant bits
// ---------------------------------------------------------------------------
module lane_select_encoder
    import lane_select_encoder_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 32,
    parameter int YELLOW_CYC = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_LANES-1:0]       car_arrive_i,
    input  logic                       car_depart_i,
    output logic [1:0]                 largest_o,
    output logic                       green_valid_o,
    output logic                       yellow_o,
    output logic [NUM_LANES*CNT_W-1:0] lane_cnt_o
);

    // A one-cycle phase still needs a 1-bit timer, hence the floor of 1.
    localparam int GT_W = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
    localparam int YT_W = (YELLOW_CYC > 1) ? $clog2(YELLOW_CYC) : 1;

    localparam logic [GT_W-1:0] GREEN_MIN_LAST = GT_W'(MIN_GREEN - 1);
    localparam logic [GT_W-1:0] GREEN_MAX_LAST = GT_W'(MAX_GREEN - 1);
    localparam logic [YT_W-1:0] YELLOW_LAST    = YT_W'(YELLOW_CYC - 1);

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       largest_q;
    logic [1:0]       largest_d;
    logic             greenValid_q;
    logic             greenValid_d;
    logic             yellow_q;
    logic             yellow_d;
    logic [GT_W-1:0]  greenTimer_q;
    logic [GT_W-1:0]  greenTimer_d;
    logic [YT_W-1:0]  yellowTimer_q;
    logic [YT_W-1:0]  yellowTimer_d;

    logic [CNT_W-1:0]     count [NUM_LANES];
    logic [NUM_LANES-1:0] laneDec;

    logic [1:0]       argmax;
    logic [CNT_W-1:0] argmaxCnt;
    logic             anyCars;
    logic [CNT_W-1:0] selCnt;
    logic             otherGreater;

    // One counter per lane. Departures only count against the lane that is
    // actually green; the counter itself refuses to go below zero.
    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        assign laneDec[i] = car_depart_i && (state_q == GREEN) && (largest_q == 2'(i));

        lane_counter #(
            .CNT_W (CNT_W)
        ) uCounter (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (car_arrive_i[i]),
            .dec_i   (laneDec[i]),
            .count_o (count[i])
        );

        assign lane_cnt_o[i*CNT_W +: CNT_W] = count[i];
    end

    // Busiest lane. The strict compare keeps the earlier (lower) index on a
    // tie, giving N>E>S>W priority.
    always_comb begin
        argmax    = LANE_N;
        argmaxCnt = count[0];
        anyCars   = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (count[i] > argmaxCnt) begin
                argmax    = 2'(i);
                argmaxCnt = count[i];
            end
            if (count[i] != '0) begin
                anyCars = 1'b1;
            end
        end
    end

    // Pre-emption test for the green lane: only a strictly larger queue
    // elsewhere counts, so a tie never cuts a green phase short.
    always_comb begin
        selCnt       = count[largest_q];
        otherGreater = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((2'(i) != largest_q) && (count[i] > selCnt)) begin
                otherGreater = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            largest_q     <= LANE_N;
            greenValid_q  <= 1'b0;
            yellow_q      <= 1'b0;
            greenTimer_q  <= '0;
            yellowTimer_q <= '0;
        end else begin
            state_q       <= state_d;
            largest_q     <= largest_d;
            greenValid_q  <= greenValid_d;
            yellow_q      <= yellow_d;
            greenTimer_q  <= greenTimer_d;
            yellowTimer_q <= yellowTimer_d;
        end
    end

    // Phase sequencing. The green timer stops at the exit cycle, so it never
    // needs to represent MAX_GREEN itself and cannot wrap.
    always_comb begin
        state_d       = state_q;
        greenTimer_d  = greenTimer_q;
        yellowTimer_d = yellowTimer_q;
        case (state_q)
            IDLE: begin
                if (anyCars) begin
                    state_d      = GREEN;
                    greenTimer_d = '0;
                end
            end
            GREEN: begin
                if ((greenTimer_q >= GREEN_MIN_LAST) &&
                    ((selCnt == '0) || otherGreater || (greenTimer_q == GREEN_MAX_LAST))) begin
                    state_d       = YELLOW;
                    yellowTimer_d = '0;
                end else begin
                    greenTimer_d = greenTimer_q + GT_W'(1);
                end
            end
            YELLOW: begin
                if (yellowTimer_q == YELLOW_LAST) begin
                    state_d = IDLE;
                end else begin
                    yellowTimer_d = yellowTimer_q + YT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs follow the next phase. The lane index is captured
    // only when leaving IDLE and is frozen through GREEN and YELLOW.
    always_comb begin
        largest_d = largest_q;
        if ((state_q == IDLE) && (state_d == GREEN)) begin
            largest_d = argmax;
        end
        greenValid_d = (state_d == GREEN);
        yellow_d     = (state_d == YELLOW);
    end

    assign largest_o     = largest_q;
    assign green_valid_o = greenValid_q;
    assign yellow_o      = yellow_q;

endmodule

// File: tb/tb_lane_select_encoder.sv
// ---------------------------------------------------------------------------
// tb_lane_select_encoder
//
// Self-checking bench for lane_select_encoder: directed scenarios with
// hand-computed expectations plus randomized traffic, all compared every
// cycle against a behavioural model of the intersection.
// ---------------------------------------------------------------------------
module tb_lane_select_encoder;
    import lane_select_encoder_pkg::*;

    localparam int CNT_W      = 4;
    localparam int MIN_GREEN  = 8;
    localparam int MAX_GREEN  = 32;
    localparam int YELLOW_CYC = 3;
    localparam int SAT        = (1 << CNT_W) - 1;

    localparam int MODE_IDLE   = 0;
    localparam int MODE_GREEN  = 1;
    localparam int MODE_YELLOW = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_LANES-1:0]       carArrive;
    logic                       carDepart;
    logic [1:0]                 largest;
    logic                       greenValid;
    logic                       yellowO;
    logic [NUM_LANES*CNT_W-1:0] laneCnt;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state.
    int mCnt [NUM_LANES];
    int oldCnt [NUM_LANES];
    int mMode;
    int mLargest;
    int mGreenAge;
    int mYellowAge;
    int bestIdx;
    bit anyWaiting;
    bit rivalBigger;

    // Phase-length monitor.
    int greenRun = 0;
    int yellowRun = 0;
    int lastGreenRun = 0;
    int lastYellowRun = 0;

    lane_select_encoder #(
        .CNT_W      (CNT_W),
        .MIN_GREEN  (MIN_GREEN),
        .MAX_GREEN  (MAX_GREEN),
        .YELLOW_CYC (YELLOW_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .car_arrive_i  (carArrive),
        .car_depart_i  (carDepart),
        .largest_o     (largest),
        .green_valid_o (greenValid),
        .yellow_o      (yellowO),
        .lane_cnt_o    (laneCnt)
    );

    always #5 clk = ~clk;

    function automatic int dutCnt(input int lane);
        return int'(laneCnt[lane*CNT_W +: CNT_W]);
    endfunction

    task automatic checkEq(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the intersection: queues move with arrivals/departures, the
    // controller picks the busiest lane and ages the green and yellow phases.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) mCnt[i] = 0;
            mMode      = MODE_IDLE;
            mLargest   = 0;
            mGreenAge  = 0;
            mYellowAge = 0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) oldCnt[i] = mCnt[i];
            for (int i = 0; i < NUM_LANES; i++) begin
                bit up;
                bit down;
                up   = carArrive[i];
                down = carDepart && (mMode == MODE_GREEN) && (i == mLargest);
                if (up && !down && oldCnt[i] < SAT) mCnt[i] = oldCnt[i] + 1;
                else if (down && !up && oldCnt[i] > 0) mCnt[i] = oldCnt[i] - 1;
            end
            if (mMode == MODE_IDLE) begin
                anyWaiting = 0;
                bestIdx    = 0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (oldCnt[i] != 0) anyWaiting = 1;
                    if (oldCnt[i] > oldCnt[bestIdx]) bestIdx = i;
                end
                if (anyWaiting) begin
                    mLargest  = bestIdx;
                    mMode     = MODE_GREEN;
                    mGreenAge = 0;
                end
            end else if (mMode == MODE_GREEN) begin
                rivalBigger = 0;
                for (int i = 0; i < NUM_LANES; i++)
                    if (i != mLargest && oldCnt[i] > oldCnt[mLargest]) rivalBigger = 1;
                if (mGreenAge + 1 >= MIN_GREEN &&
                    (oldCnt[mLargest] == 0 || rivalBigger || mGreenAge + 1 == MAX_GREEN)) begin
                    mMode      = MODE_YELLOW;
                    mYellowAge = 0;
                end else begin
                    mGreenAge++;
                end
            end else begin
                if (mYellowAge + 1 == YELLOW_CYC) mMode = MODE_IDLE;
                else mYellowAge++;
            end
        end
    end

    task automatic checkOutput();
        checkEq("largest", int'(largest), mLargest);
        checkEq("green_valid", int'(greenValid), (mMode == MODE_GREEN) ? 1 : 0);
        checkEq("yellow", int'(yellowO), (mMode == MODE_YELLOW) ? 1 : 0);
        checkEq("green_yellow_exclusive", int'(greenValid & yellowO), 0);
        for (int i = 0; i < NUM_LANES; i++) begin
            checkEq($sformatf("lane_cnt[%0d]", i), dutCnt(i), mCnt[i]);
        end
    endtask

    // Per-cycle comparison against the model, one step after each edge.
    always @(posedge clk) begin
        #1;
        checkOutput();
    end

    // Measures how many cycles each green and yellow phase lasted.
    always @(negedge clk) begin
        if (greenValid) greenRun++;
        else if (greenRun > 0) begin
            lastGreenRun = greenRun;
            greenRun     = 0;
        end
        if (yellowO) yellowRun++;
        else if (yellowRun > 0) begin
            lastYellowRun = yellowRun;
            yellowRun     = 0;
        end
    end

    task automatic applyStimulus(input logic [NUM_LANES-1:0] arrive, input logic depart);
        @(negedge clk);
        carArrive = arrive;
        carDepart = depart;
    endtask

    task automatic resetBench();
        @(negedge clk);
        carArrive = '0;
        carDepart = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        greenRun      = 0;
        yellowRun     = 0;
        lastGreenRun  = 0;
        lastYellowRun = 0;
        rst_n         = 1'b1;
    endtask

    task automatic waitGreen(input int budget);
        int n = 0;
        while (!greenValid && n < budget) begin
            applyStimulus('0, 1'b0);
            n++;
        end
        if (!greenValid) checkEq("wait_green_timeout", 0, 1);
    endtask

    task automatic waitYellowEnd(input int budget);
        int n = 0;
        while (!yellowO && n < budget) begin
            applyStimulus('0, 1'b0);
            n++;
        end
        while (yellowO && n < budget) begin
            applyStimulus('0, 1'b0);
            n++;
        end
        if (n >= budget) checkEq("wait_yellow_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        carArrive = '0;
        carDepart = 1'b0;
        #2;
        checkEq("reset_largest", int'(largest), 0);
        checkEq("reset_green", int'(greenValid), 0);
        checkEq("reset_yellow", int'(yellowO), 0);
        checkEq("reset_cnt", int'(laneCnt), 0);
        resetBench();

        // Three arrivals on E: green one cycle after the first count shows,
        // no departures so the phase runs to the green ceiling.
        applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        checkEq("e_first_count", dutCnt(LANE_E), 1);
        checkEq("e_not_green_yet", int'(greenValid), 0);
        applyStimulus(4'b0010, 1'b0);
        checkEq("e_green", int'(greenValid), 1);
        checkEq("e_largest", int'(largest), int'(LANE_E));
        waitYellowEnd(100);
        checkEq("e_green_len", lastGreenRun, 32);
        checkEq("e_yellow_len", lastYellowRun, 3);
        checkEq("e_cnt_kept", dutCnt(LANE_E), 3);
        checkEq("e_all_red", int'(greenValid | yellowO), 0);

        // N and S tied at 2: N wins; emptying N still waits for the minimum.
        resetBench();
        applyStimulus(4'b0101, 1'b0);
        applyStimulus(4'b0101, 1'b0);
        applyStimulus('0, 1'b1);
        checkEq("tie_green", int'(greenValid), 1);
        checkEq("tie_largest", int'(largest), int'(LANE_N));
        checkEq("tie_cnt_n", dutCnt(LANE_N), 2);
        checkEq("tie_cnt_s", dutCnt(LANE_S), 2);
        applyStimulus('0, 1'b1);
        waitYellowEnd(100);
        checkEq("tie_green_len", lastGreenRun, 8);
        checkEq("tie_cnt_n_empty", dutCnt(LANE_N), 0);
        checkEq("tie_cnt_s_kept", dutCnt(LANE_S), 2);
        checkEq("tie_all_red", int'(greenValid), 0);
        waitGreen(10);
        checkEq("tie_next_largest", int'(largest), int'(LANE_S));

        // W green with one car; E overtakes at green cycle 10.
        resetBench();
        applyStimulus(4'b1000, 1'b0);
        waitGreen(10);
        checkEq("w_largest", int'(largest), int'(LANE_W));
        for (int i = 0; i < 9; i++) applyStimulus('0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 1'b0);
        waitYellowEnd(100);
        checkEq("w_green_len", lastGreenRun, 13);
        checkEq("w_yellow_len", lastYellowRun, 3);
        checkEq("w_all_red", int'(greenValid), 0);
        waitGreen(10);
        checkEq("w_then_e", int'(largest), int'(LANE_E));

        // Saturation on N, then arrive+depart together at the ceiling.
        resetBench();
        for (int i = 0; i < 20; i++) applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        checkEq("sat_cnt", dutCnt(LANE_N), 15);
        checkEq("sat_green", int'(greenValid), 1);
        applyStimulus('0, 1'b0);
        checkEq("sat_arrive_depart", dutCnt(LANE_N), 15);

        // Departures while yellow and while idle leave the queues alone.
        begin
            int n = 0;
            while (!yellowO && n < 100) begin
                applyStimulus('0, 1'b0);
                n++;
            end
            checkEq("sat_reach_yellow", int'(yellowO), 1);
        end
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkEq("yellow_depart_ignored", dutCnt(LANE_N), 15);
        begin
            int n = 0;
            while (yellowO && n < 10) begin
                applyStimulus('0, 1'b0);
                n++;
            end
        end
        checkEq("idle_before_depart", int'(greenValid | yellowO), 0);
        carDepart = 1'b1;
        applyStimulus('0, 1'b0);
        checkEq("idle_depart_ignored", dutCnt(LANE_N), 15);
        checkEq("idle_to_green", int'(greenValid), 1);

        // Asynchronous reset in the middle of a green phase.
        applyStimulus('0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkEq("async_rst_cnt", int'(laneCnt), 0);
        checkEq("async_rst_green", int'(greenValid), 0);
        checkEq("async_rst_yellow", int'(yellowO), 0);
        checkEq("async_rst_largest", int'(largest), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus('0, 1'b0);
        checkEq("post_rst_idle", int'(greenValid | yellowO), 0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NUM_LANES-1:0] arr;
            for (int i = 0; i < NUM_LANES; i++) arr[i] = ($urandom_range(0, 6) == 0);
            applyStimulus(arr, ($urandom_range(0, 2) == 0));
        end
        applyStimulus('0, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
